// File: rtl/fetch_unit.sv
// fetch_unit: front end of the multicycle core. Owns the program counter and
// the instruction register, fetches 16-bit words from instruction memory over
// a req/ack handshake with a bounded wait, and applies PC writes requested by
// the control FSM.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   EscLR           fetch request (level-sampled in IDLE)
//   EscCP           unconditional PC write
//   EscCondCP, Zero conditional PC write, taken when Zero is set
//   FonteCP         next-PC source: 00 ALU, 01 PC+simm4, 10 page jump, 11 hold
//   ULA_Res         ALU result
//   IMEM_Req/Addr   memory request and registered fetch address
//   IMEM_Ack/Data   memory data valid and instruction word
//   CodOP..RegT     IR field slices
//   PC              current program counter
//   IR_Valid        IR holds a completed fetch
//   Stall           fetch in flight
//   Fetch_Err       sticky fetch-timeout flag
module fetch_unit #(
  parameter int unsigned   PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned   TIMEOUT  = 15
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EscLR,
  input  logic            EscCP,
  input  logic            EscCondCP,
  input  logic [1:0]      FonteCP,
  input  logic [PC_W-1:0] ULA_Res,
  input  logic            Zero,
  output logic            IMEM_Req,
  output logic [PC_W-1:0] IMEM_Addr,
  input  logic            IMEM_Ack,
  input  logic [15:0]     IMEM_Data,
  output logic [3:0]      CodOP,
  output logic [3:0]      RegD,
  output logic [3:0]      RegS,
  output logic [3:0]      RegT,
  output logic [PC_W-1:0] PC,
  output logic            IR_Valid,
  output logic            Stall,
  output logic            Fetch_Err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic              req_q, req_d;
  logic              valid_q, valid_d;
  logic              stall_q, stall_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pcw;
  logic [PC_W-1:0]   pc_sel;

  // State register; reset overrides everything, abandoning any in-flight fetch
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-PC source mux; PC-relative offset is the sign-extended RegT field
  always_comb begin
    pc_sel = pc_q;
    unique case (FonteCP)
      2'b00:   pc_sel = ULA_Res;
      2'b01:   pc_sel = pc_q + {{(PC_W-4){ir_q[3]}}, ir_q[3:0]};
      2'b10:   pc_sel = {pc_q[PC_W-1:12], ir_q[11:0]};
      default: pc_sel = pc_q;
    endcase
  end

  assign pcw = EscCP | (EscCondCP & Zero);

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    pc_d    = pcw ? pc_sel : pc_q;
    ir_d    = ir_q;
    addr_d  = addr_q;
    req_d   = req_q;
    valid_d = valid_q;
    stall_d = stall_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        // Address captures the pre-write PC even if pcw fires this cycle
        if (EscLR) begin
          state_d = FETCH;
          addr_d  = pc_q;
          req_d   = 1'b1;
          stall_d = 1'b1;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      end
      FETCH: begin
        if (IMEM_Ack) begin
          state_d = IDLE;
          ir_d    = IMEM_Data;
          req_d   = 1'b0;
          stall_d = 1'b0;
          valid_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          req_d   = 1'b0;
          stall_d = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign IMEM_Req  = req_q;
  assign IMEM_Addr = addr_q;
  assign PC        = pc_q;
  assign IR_Valid  = valid_q;
  assign Stall     = stall_q;
  assign Fetch_Err = err_q;
  assign CodOP     = ir_q[15:12];
  assign RegD      = ir_q[11:8];
  assign RegS      = ir_q[7:4];
  assign RegT      = ir_q[3:0];

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        EscLR = 1'b0;
  logic        EscCP = 1'b0;
  logic        EscCondCP = 1'b0;
  logic [1:0]  FonteCP = 2'b11;
  logic [15:0] ULA_Res = '0;
  logic        Zero = 1'b0;
  logic        IMEM_Req;
  logic [15:0] IMEM_Addr;
  logic        IMEM_Ack = 1'b0;
  logic [15:0] IMEM_Data = '0;
  logic [3:0]  CodOP, RegD, RegS, RegT;
  logic [15:0] PC;
  logic        IR_Valid, Stall, Fetch_Err;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.PC_W(16), .RESET_PC(16'h0000), .TIMEOUT(15)) dut (
    .CLK(CLK), .RST(RST), .EscLR(EscLR), .EscCP(EscCP), .EscCondCP(EscCondCP),
    .FonteCP(FonteCP), .ULA_Res(ULA_Res), .Zero(Zero),
    .IMEM_Req(IMEM_Req), .IMEM_Addr(IMEM_Addr), .IMEM_Ack(IMEM_Ack),
    .IMEM_Data(IMEM_Data), .CodOP(CodOP), .RegD(RegD), .RegS(RegS), .RegT(RegT),
    .PC(PC), .IR_Valid(IR_Valid), .Stall(Stall), .Fetch_Err(Fetch_Err)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Load PC directly from the ALU path
  task automatic set_pc(input logic [15:0] v);
    EscCP = 1'b1; FonteCP = 2'b00; ULA_Res = v;
    tick();
    EscCP = 1'b0; FonteCP = 2'b11;
  endtask

  // Single-cycle-ack fetch used to preload IR
  task automatic quick_fetch(input logic [15:0] d);
    EscLR = 1'b1;
    tick();
    EscLR = 1'b0; IMEM_Ack = 1'b1; IMEM_Data = d;
    tick();
    IMEM_Ack = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if ({IMEM_Req, IMEM_Addr, PC, CodOP, RegD, RegS, RegT, IR_Valid, Stall, Fetch_Err} !== '0) begin
      failures++;
      $display("FAIL reset: req=%b addr=%h pc=%h ir=%h%h%h%h valid=%b stall=%b err=%b required all zero",
               IMEM_Req, IMEM_Addr, PC, CodOP, RegD, RegS, RegT, IR_Valid, Stall, Fetch_Err);
    end
  endtask

  task automatic test_basic_fetch();
    int req_cycles = 0;
    EscLR = 1'b1;
    tick();
    EscLR = 1'b0;
    checks++;
    if (IMEM_Req !== 1'b1 || IMEM_Addr !== 16'h0000 || Stall !== 1'b1) begin
      failures++;
      $display("FAIL fetch_start: req=%b addr=%h stall=%b required 1 0000 1", IMEM_Req, IMEM_Addr, Stall);
    end
    if (IMEM_Req) req_cycles++;
    tick(); if (IMEM_Req) req_cycles++;
    tick(); if (IMEM_Req) req_cycles++;
    IMEM_Ack = 1'b1; IMEM_Data = 16'hB123;
    tick();
    IMEM_Ack = 1'b0; IMEM_Data = 16'h0000;
    if (IMEM_Req) req_cycles++;
    checks++;
    if (req_cycles != 3) begin
      failures++;
      $display("FAIL req_len: got %0d cycles required 3", req_cycles);
    end
    checks++;
    if (IR_Valid !== 1'b1 || Stall !== 1'b0 || {CodOP, RegD, RegS, RegT} !== 16'hB123) begin
      failures++;
      $display("FAIL fetch_done: valid=%b stall=%b ir=%h%h%h%h required 1 0 b123",
               IR_Valid, Stall, CodOP, RegD, RegS, RegT);
    end
    // Ack while idle must not reload IR or raise a request
    IMEM_Ack = 1'b1; IMEM_Data = 16'h7777;
    tick();
    IMEM_Ack = 1'b0;
    checks++;
    if (IMEM_Req !== 1'b0 || {CodOP, RegD, RegS, RegT} !== 16'hB123) begin
      failures++;
      $display("FAIL idle_ack: req=%b ir=%h%h%h%h required 0 b123", IMEM_Req, CodOP, RegD, RegS, RegT);
    end
  endtask

  task automatic test_jump();
    set_pc(16'h5004);
    EscCP = 1'b1; FonteCP = 2'b10;
    tick();
    EscCP = 1'b0; FonteCP = 2'b11;
    checks++;
    if (PC !== 16'h5123) begin
      failures++;
      $display("FAIL jump: pc=%h required 5123", PC);
    end
  endtask

  task automatic test_branch();
    quick_fetch(16'h100E);
    set_pc(16'h0010);
    EscCondCP = 1'b1; FonteCP = 2'b01; Zero = 1'b1;
    tick();
    checks++;
    if (PC !== 16'h000E) begin
      failures++;
      $display("FAIL branch_taken: pc=%h required 000e", PC);
    end
    EscCondCP = 1'b0; FonteCP = 2'b11;
    set_pc(16'h0010);
    EscCondCP = 1'b1; FonteCP = 2'b01; Zero = 1'b0;
    tick();
    EscCondCP = 1'b0; FonteCP = 2'b11;
    checks++;
    if (PC !== 16'h0010) begin
      failures++;
      $display("FAIL branch_not_taken: pc=%h required 0010", PC);
    end
    quick_fetch(16'h2001);
    set_pc(16'hFFFF);
    EscCP = 1'b1; FonteCP = 2'b01;
    tick();
    EscCP = 1'b0; FonteCP = 2'b11;
    checks++;
    if (PC !== 16'h0000) begin
      failures++;
      $display("FAIL pc_wrap: pc=%h required 0000", PC);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    EscLR = 1'b1;
    tick();
    EscLR = 1'b0;
    while (IMEM_Req === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != 15) begin
      failures++;
      $display("FAIL timeout_len: req fell after %0d cycles required 15", n);
    end
    checks++;
    if (Fetch_Err !== 1'b1 || IR_Valid !== 1'b0 || Stall !== 1'b0 || {CodOP, RegD, RegS, RegT} !== 16'h2001) begin
      failures++;
      $display("FAIL timeout_state: err=%b valid=%b stall=%b ir=%h%h%h%h required 1 0 0 2001",
               Fetch_Err, IR_Valid, Stall, CodOP, RegD, RegS, RegT);
    end
    tick(); tick();
    checks++;
    if (Fetch_Err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: err=%b required 1", Fetch_Err);
    end
    quick_fetch(16'h3456);
    checks++;
    if (IR_Valid !== 1'b1 || Fetch_Err !== 1'b1 || {CodOP, RegD, RegS, RegT} !== 16'h3456) begin
      failures++;
      $display("FAIL refetch_after_err: valid=%b err=%b ir=%h%h%h%h required 1 1 3456",
               IR_Valid, Fetch_Err, CodOP, RegD, RegS, RegT);
    end
  endtask

  task automatic test_back_to_back();
    set_pc(16'h0010);
    EscLR = 1'b1;
    tick();
    EscLR = 1'b0;
    EscCP = 1'b1; FonteCP = 2'b00; ULA_Res = 16'h0042;
    tick();
    EscCP = 1'b0; FonteCP = 2'b11;
    checks++;
    if (IMEM_Addr !== 16'h0010 || PC !== 16'h0042 || IMEM_Req !== 1'b1) begin
      failures++;
      $display("FAIL midfetch_pcw: addr=%h pc=%h req=%b required 0010 0042 1", IMEM_Addr, PC, IMEM_Req);
    end
    // Request during FETCH is ignored
    EscLR = 1'b1; IMEM_Ack = 1'b1; IMEM_Data = 16'h1111;
    tick();
    EscLR = 1'b0; IMEM_Ack = 1'b0;
    checks++;
    if (IMEM_Req !== 1'b0 || IR_Valid !== 1'b1) begin
      failures++;
      $display("FAIL no_queue: req=%b valid=%b required 0 1", IMEM_Req, IR_Valid);
    end
    EscLR = 1'b1;
    tick();
    EscLR = 1'b0;
    checks++;
    if (IMEM_Addr !== 16'h0042) begin
      failures++;
      $display("FAIL next_fetch_addr: addr=%h required 0042", IMEM_Addr);
    end
    IMEM_Ack = 1'b1;
    tick();
    IMEM_Ack = 1'b0;
    EscLR = 1'b1; EscCP = 1'b1; FonteCP = 2'b00; ULA_Res = 16'h0077;
    tick();
    EscLR = 1'b0; EscCP = 1'b0; FonteCP = 2'b11;
    checks++;
    if (IMEM_Addr !== 16'h0042 || PC !== 16'h0077) begin
      failures++;
      $display("FAIL simul_pcw: addr=%h pc=%h required 0042 0077", IMEM_Addr, PC);
    end
    IMEM_Ack = 1'b1;
    tick();
    IMEM_Ack = 1'b0;
  endtask

  task automatic test_reset_midfetch();
    EscLR = 1'b1;
    tick();
    EscLR = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    IMEM_Ack = 1'b1; IMEM_Data = 16'hFFFF;
    tick();
    IMEM_Ack = 1'b0;
    checks++;
    if ({CodOP, RegD, RegS, RegT} !== 16'h0000 || IR_Valid !== 1'b0 || IMEM_Req !== 1'b0 ||
        PC !== 16'h0000 || Fetch_Err !== 1'b0 || Stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_midfetch: ir=%h%h%h%h valid=%b req=%b pc=%h err=%b stall=%b required 0000 0 0 0000 0 0",
               CodOP, RegD, RegS, RegT, IR_Valid, IMEM_Req, PC, Fetch_Err, Stall);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic_fetch();
    test_jump();
    test_branch();
    test_timeout();
    test_back_to_back();
    test_reset_midfetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Upstream stage of the multicycle control FSM: owns the program counter (PC) and the instruction register (IR).
- Fetches 16-bit instructions from instruction memory through a req/ack handshake.
- Decodes IR fields; CodOP feeds the control FSM.
- Applies PC writes commanded by the control FSM (EscCP, EscCondCP, FonteCP).

Parameters:
PC_W, 16, width of PC and instruction-memory address
RESET_PC, 16'h0000, PC value after reset
TIMEOUT, 15, max cycles to wait for IMEM_Ack before aborting a fetch (>=1)

Ports:
CLK  in  1  clock; all state updates on posedge
RST  in  1  synchronous reset, active-high
EscLR  in  1  fetch request from control FSM; level-sampled
EscCP  in  1  unconditional PC write
EscCondCP  in  1  conditional PC write, qualified by Zero
FonteCP  in  2  PC source select
ULA_Res  in  PC_W  ALU result
Zero  in  1  ALU zero flag
IMEM_Req  out  1  memory request
IMEM_Addr  out  PC_W  fetch address, registered
IMEM_Ack  in  1  memory data valid
IMEM_Data  in  16  instruction word
CodOP  out  4  IR[15:12]
RegD  out  4  IR[11:8]
RegS  out  4  IR[7:4]
RegT  out  4  IR[3:0], also the 4-bit immediate
PC  out  PC_W  current PC
IR_Valid  out  1  IR holds a completed fetch
Stall  out  1  fetch in flight
Fetch_Err  out  1  sticky timeout flag

Behaviour:
- Reset (RST high at posedge) forces: PC=RESET_PC, IR=0, IMEM_Req=0, IMEM_Addr=0, IR_Valid=0, Stall=0, Fetch_Err=0, wait counter=0, state IDLE. Reset takes priority over every other input, including an in-flight fetch; that fetch is abandoned and a late Ack is ignored.
- States:
  - IDLE:
    - EscLR=1 -> FETCH; IMEM_Addr<=PC; IMEM_Req<=1; Stall<=1; IR_Valid<=0; counter<=0.
  - FETCH:
    - IMEM_Ack=1 -> IR<=IMEM_Data; IMEM_Req<=0; Stall<=0; IR_Valid<=1; -> IDLE. Fetch latency is 1 cycle after Ack is sampled.
    - Otherwise counter increments. When counter reaches TIMEOUT-1 without Ack: IMEM_Req<=0; Stall<=0; Fetch_Err<=1; IR unchanged; IR_Valid stays 0; -> IDLE.
    - EscLR during FETCH is ignored; no request is queued.
- Ack sampled in IDLE is ignored.
- IMEM_Req is deasserted the cycle after Ack. Memory must drop Ack once Req is low.
- Fetch_Err clears only on RST.
- PC write enable: pcw = EscCP | (EscCondCP & Zero). pcw is evaluated every cycle, in any state.
- Next PC by FonteCP:
  - 00: ULA_Res
  - 01: PC + sign-extended RegT; wraps modulo 2^PC_W
  - 10: {PC[PC_W-1:12], IR[11:0]}
  - 11: PC unchanged
- A PC write during FETCH does not alter IMEM_Addr of the in-flight request. The new PC is used by the next fetch.
- EscLR and pcw in the same IDLE cycle: IMEM_Addr takes the old PC; PC takes the new value.
- CodOP/RegD/RegS/RegT are combinational slices of IR and change only when IR loads.
- PC, IMEM_Addr and all state are registered; no combinational path from IMEM_Ack to IMEM_Req.

Test Plan:
- Reset then basic fetch: RST 1 cycle, EscLR=1, IMEM_Data=16'hB123, Ack 2 cycles after Req -> IMEM_Addr=0000, Req high 3 cycles, then IR_Valid=1, CodOP=4'hB, RegD=1, RegS=2, RegT=3.
- Jump: IR=16'hB123, PC=16'h5004, EscCP=1, FonteCP=10 -> PC=16'h5123 next cycle.
- Conditional branch, both outcomes: IR RegT=4'hE (-2), PC=0010, EscCondCP=1, FonteCP=01. Zero=1 -> PC=000E; Zero=0 -> PC stays 0010. Also PC=FFFF with RegT=1 -> PC=0000 (wrap).
- Timeout: EscLR=1, Ack never asserted, TIMEOUT=15 -> Req falls after 15 cycles, Fetch_Err=1 sticky, IR_Valid=0. Next EscLR starts a fresh fetch with Fetch_Err still 1.
- PC write mid-fetch and simultaneous events:
  - EscCP=1, FonteCP=00, ULA_Res=0042 while FETCH from 0010 -> IMEM_Addr stays 0010; next fetch uses 0042.
  - EscLR with pcw in the same IDLE cycle -> address is the old PC.
- Reset mid-fetch: RST during FETCH, then Ack arrives -> IR stays 0, IR_Valid=0, Req=0, PC=RESET_PC.
